// File: rtl/adc_sample_sequencer_if.sv
// Bundle of the sequencer's control, ADC-engine and downstream result signals.
// The master modport is the sequencer's own view; slave is the surrounding logic.
interface adc_sample_sequencer_if #(
   parameter int DATA_W   = 12,
   parameter int PERIOD_W = 16
);
   logic                enable;
   logic [PERIOD_W-1:0] period;
   logic                adc_start;
   logic                adc_done;
   logic [DATA_W-1:0]   adc_dato;
   logic [DATA_W-1:0]   sample_out;
   logic                sample_valid;
   logic                sample_ready;
   logic                overrun;
   logic                timeout_err;
   logic                busy;

   modport master (
      input  enable, period, adc_done, adc_dato, sample_ready,
      output adc_start, sample_out, sample_valid, overrun, timeout_err, busy
   );

   modport slave (
      output enable, period, adc_done, adc_dato, sample_ready,
      input  adc_start, sample_out, sample_valid, overrun, timeout_err, busy
   );
endinterface

// File: rtl/adc_sample_sequencer.sv
// Sample scheduler for the serial ADC engine: periodic start pulses, done capture,
// box averaging of 2^AVG_LOG words, valid/ready result hand-off, and
// timeout / overrun reporting.
module adc_sample_sequencer #(
   parameter int DATA_W   = 12,
   parameter int PERIOD_W = 16,
   parameter int AVG_LOG  = 2,
   parameter int TIMEOUT  = 40
) (
   input  logic                   Clock_Muestreo,
   input  logic                   reset,
   adc_sample_sequencer_if.master bus
);
   localparam int ACC_W = DATA_W + AVG_LOG;
   localparam int CNT_W = AVG_LOG + 1;
   localparam int TMO_W = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] AVG_N = CNT_W'(2 ** AVG_LOG);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_WAIT    = 3'd1;
   localparam logic [2:0] S_START   = 3'd2;
   localparam logic [2:0] S_CONVERT = 3'd3;
   localparam logic [2:0] S_ACCUM   = 3'd4;

   logic [2:0]          state_q,   state_d;
   logic [PERIOD_W-1:0] per_cnt_q, per_cnt_d;
   logic                pend_q,    pend_d;
   logic [TMO_W-1:0]    tmo_cnt_q, tmo_cnt_d;
   logic [ACC_W-1:0]    acc_q,     acc_d;
   logic [CNT_W-1:0]    cnt_q,     cnt_d;
   logic [DATA_W-1:0]   out_q,     out_d;
   logic                valid_q,   valid_d;
   logic                ovr_q,     ovr_d;
   logic                tmo_err_q, tmo_err_d;
   logic                tick;

   // Period 0 or 1 means a tick every cycle; otherwise the counter phase decides.
   assign tick = (bus.period <= PERIOD_W'(1)) ||
                 (per_cnt_q == bus.period - PERIOD_W'(1));

   // Next-state logic for the schedule FSM and the averaging datapath.
   always_comb begin
      // NOTE: every _d gets a default before the case so no path leaves it
      // unassigned; a missing default here would infer a latch.
      state_d   = state_q;
      per_cnt_d = tick ? '0 : per_cnt_q + PERIOD_W'(1);
      pend_d    = pend_q;
      tmo_cnt_d = tmo_cnt_q;
      acc_d     = acc_q;
      cnt_d     = cnt_q;
      out_d     = out_q;
      valid_d   = valid_q && !bus.sample_ready;
      ovr_d     = 1'b0;
      tmo_err_d = 1'b0;

      case (state_q)
         S_IDLE: begin
            per_cnt_d = '0;
            pend_d    = 1'b0;
            acc_d     = '0;
            cnt_d     = '0;
            if (bus.enable) state_d = S_START;
         end

         S_WAIT: begin
            if (!bus.enable) begin
               state_d = S_IDLE;
               acc_d   = '0;
               cnt_d   = '0;
            end else if (tick || pend_q) begin
               state_d = S_START;
            end
         end

         S_START: begin
            // The start cycle is phase 0 of the period, so the next cycle is phase 1.
            per_cnt_d = PERIOD_W'(1);
            pend_d    = 1'b0;
            tmo_cnt_d = TMO_W'(1);
            state_d   = S_CONVERT;
         end

         S_CONVERT: begin
            if (tick) pend_d = 1'b1;
            tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
            if (bus.adc_done) begin
               if (!bus.enable) begin
                  // Engine finished the frame it had begun; the word is dropped.
                  state_d = S_IDLE;
                  acc_d   = '0;
                  cnt_d   = '0;
               end else begin
                  acc_d   = acc_q + ACC_W'(bus.adc_dato);
                  cnt_d   = cnt_q + CNT_W'(1);
                  state_d = S_ACCUM;
               end
            end else if (tmo_cnt_q >= TMO_W'(TIMEOUT - 1)) begin
               // Hung conversion: discard the partial average and realign to the grid.
               tmo_err_d = 1'b1;
               acc_d     = '0;
               cnt_d     = '0;
               pend_d    = 1'b0;
               state_d   = bus.enable ? S_WAIT : S_IDLE;
            end
         end

         S_ACCUM: begin
            if (cnt_q == AVG_N) begin
               out_d   = DATA_W'(acc_q >> AVG_LOG);
               valid_d = 1'b1;
               ovr_d   = valid_q && !bus.sample_ready;
               acc_d   = '0;
               cnt_d   = '0;
            end
            if (!bus.enable)          state_d = S_IDLE;
            else if (tick || pend_q)  state_d = S_START;
            else                      state_d = S_WAIT;
         end

         default: state_d = S_IDLE;
      endcase
   end

   // State and datapath registers; everything clears asynchronously on reset.
   always_ff @(posedge Clock_Muestreo or negedge reset) begin
      // NOTE: non-blocking assignments so every register samples the pre-edge
      // value of its neighbours, independent of statement order.
      if (!reset) begin
         state_q   <= S_IDLE;
         per_cnt_q <= '0;
         pend_q    <= 1'b0;
         tmo_cnt_q <= '0;
         acc_q     <= '0;
         cnt_q     <= '0;
         out_q     <= '0;
         valid_q   <= 1'b0;
         ovr_q     <= 1'b0;
         tmo_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         per_cnt_q <= per_cnt_d;
         pend_q    <= pend_d;
         tmo_cnt_q <= tmo_cnt_d;
         acc_q     <= acc_d;
         cnt_q     <= cnt_d;
         out_q     <= out_d;
         valid_q   <= valid_d;
         ovr_q     <= ovr_d;
         tmo_err_q <= tmo_err_d;
      end
   end

   assign bus.adc_start    = (state_q == S_START);
   assign bus.busy         = (state_q != S_IDLE);
   assign bus.sample_out   = out_q;
   assign bus.sample_valid = valid_q;
   assign bus.overrun      = ovr_q;
   assign bus.timeout_err  = tmo_err_q;
endmodule
